// File: rtl/seq_detect_p_pkg.sv
// Shared types and reset constants for the programmable serial pattern detector.
// Optional match counter is enabled with SEQ_DETECT_P_CNT_EN.
package seq_detect_p_pkg;

    typedef logic [1:0] state_t;

    localparam state_t EMPTY = 2'd0;
    localparam state_t FILL  = 2'd1;
    localparam state_t ARMED = 2'd2;

    localparam logic [2:0] RST_PAT = 3'b101;
    localparam int         RST_LEN = 3;
    localparam logic       RST_OVL = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used by seq_detect_p when SEQ_DETECT_P_CNT_EN is defined.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_p.sv
// Runtime-configurable Mealy sequence detector, overlapping or not.
// Define SEQ_DETECT_P_CNT_EN to add the saturating match_cnt output.
module seq_detect_p
    import seq_detect_p_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         x,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pat,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_ovl,
    output logic                         y,
    output logic                         cfg_err
`ifdef SEQ_DETECT_P_CNT_EN
    ,
    output logic [CNT_W-1:0]             match_cnt
`endif
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [MAX_LEN:0] ONE = (MAX_LEN + 1)'(1);

    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      len;
    logic [LW-1:0]      fill;
    logic               ovl;
    state_t             state;

    logic [MAX_LEN:0]   mask;
    logic [MAX_LEN:0]   diff;
    logic               cfg_ok;
    logic               hit;
    logic [LW-1:0]      fill_inc;
    logic [LW-1:0]      fill_nx;
    state_t             state_nx;

    assign cfg_ok = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));

    // Only the low len bits of {hist, x} take part in the compare.
    assign mask = (ONE << len) - ONE;
    assign diff = ({hist, x} ^ {1'b0, pat}) & mask;
    assign hit  = (state == ARMED) && (diff == '0);
    assign y    = en && !cfg_we && hit;

    assign fill_inc = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
    assign fill_nx  = (y && !ovl) ? '0 : fill_inc;

    always_comb begin
        state_nx = FILL;
        if (fill_nx == '0) begin
            state_nx = EMPTY;
        end else if (fill_nx >= len - LW'(1)) begin
            state_nx = ARMED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat     <= MAX_LEN'(RST_PAT);
            len     <= LW'(RST_LEN);
            ovl     <= RST_OVL;
            hist    <= '0;
            fill    <= '0;
            state   <= EMPTY;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we) begin
                // A rejected load drops this x but keeps the stream intact.
                if (cfg_ok) begin
                    pat   <= cfg_pat;
                    len   <= cfg_len;
                    ovl   <= cfg_ovl;
                    hist  <= '0;
                    fill  <= '0;
                    state <= EMPTY;
                end
            end else if (en) begin
                hist  <= {hist[MAX_LEN-2:0], x};
                fill  <= fill_nx;
                state <= state_nx;
            end
        end
    end

`ifdef SEQ_DETECT_P_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cfg_we && cfg_ok),
        .inc(y),
        .cnt(match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_p.sv
// Testbench for seq_detect_p: vector table plus hand-written corner sequences.
// Counter checks are compiled in when SEQ_DETECT_P_CNT_EN is defined.
module tb_seq_detect_p;

    localparam int ML = 8;
`ifdef SEQ_DETECT_P_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          x;
    logic          cfg_we;
    logic [ML-1:0] cfg_pat;
    logic [3:0]    cfg_len;
    logic          cfg_ovl;
    logic          y;
    logic          cfg_err;
`ifdef SEQ_DETECT_P_CNT_EN
    logic [CW-1:0] match_cnt;
`endif

    seq_detect_p #(
        .MAX_LEN(ML),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .x(x),
        .cfg_we(cfg_we),
        .cfg_pat(cfg_pat),
        .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl),
        .y(y),
        .cfg_err(cfg_err)
`ifdef SEQ_DETECT_P_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       x;
        logic       we;
        logic [3:0] len;
        logic [7:0] pat;
        logic       ovl;
        logic       ey;
        logic       eerr;
    } vec_t;

    typedef struct {
        logic y;
        logic err;
        int   id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic e, input logic xx,
                                input logic we, input logic [3:0] l,
                                input logic [7:0] p, input logic o,
                                input logic ey, input logic eerr);
        vec_t v;
        v = '{e, xx, we, l, p, o, ey, eerr};
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        en      = v.en;
        x       = v.x;
        cfg_we  = v.we;
        cfg_len = v.len;
        cfg_pat = v.pat;
        cfg_ovl = v.ovl;
        e = '{v.ey, v.eerr, id};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty want entry");
        end else begin
            e = sb.pop_front();
            chk($sformatf("y[%0d]", e.id), 32'(y), 32'(e.y));
            chk($sformatf("cfg_err[%0d]", e.id), 32'(cfg_err), 32'(e.err));
        end
    endtask

    task automatic run(input vec_t v, input int id);
        drive(v, id);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic e, input logic xx, input logic we,
                       input logic [3:0] l, input logic [7:0] p,
                       input logic o, input logic ey, input logic eerr,
                       input int id);
        vec_t v;
        v = '{e, xx, we, l, p, o, ey, eerr};
        run(v, id);
    endtask

    initial begin
        // Defaults 101/3/overlap: 1,0,1,0,1 hits on bits 3 and 5
        add(1, 1, 0, 3, 8'h05, 1, 0, 0);
        add(1, 0, 0, 3, 8'h05, 1, 0, 0);
        add(1, 1, 0, 3, 8'h05, 1, 1, 0);
        add(1, 0, 0, 3, 8'h05, 1, 0, 0);
        add(1, 1, 0, 3, 8'h05, 1, 1, 0);
        // 1011 overlapping: hits on bits 4 and 7
        add(1, 1, 1, 4, 8'h0B, 1, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 1, 0, 0);
        add(1, 0, 0, 4, 8'h0B, 1, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 1, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 1, 1, 0);
        add(1, 0, 0, 4, 8'h0B, 1, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 1, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 1, 1, 0);
        // 1011 non-overlapping: hit on bit 4 only
        add(1, 1, 1, 4, 8'h0B, 0, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 0, 0, 0);
        add(1, 0, 0, 4, 8'h0B, 0, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 0, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 0, 1, 0);
        add(1, 0, 0, 4, 8'h0B, 0, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 0, 0, 0);
        add(1, 1, 0, 4, 8'h0B, 0, 0, 0);
        // 101 with en gaps carrying x=1
        add(0, 0, 1, 3, 8'h05, 1, 0, 0);
        add(1, 1, 0, 3, 8'h05, 1, 0, 0);
        add(0, 1, 0, 3, 8'h05, 1, 0, 0);
        add(1, 0, 0, 3, 8'h05, 1, 0, 0);
        add(0, 1, 0, 3, 8'h05, 1, 0, 0);
        add(1, 1, 0, 3, 8'h05, 1, 1, 0);
        // Rejected len=1, detection of 101 continues
        add(0, 0, 1, 1, 8'h00, 0, 0, 0);
        add(1, 1, 0, 3, 8'h05, 1, 0, 1);
        add(1, 0, 0, 3, 8'h05, 1, 0, 0);
        add(1, 1, 0, 3, 8'h05, 1, 1, 0);
        // Rejected len=9
        add(0, 0, 1, 9, 8'hFF, 0, 0, 0);
        add(1, 0, 0, 3, 8'h05, 1, 0, 1);
        add(1, 1, 0, 3, 8'h05, 1, 1, 0);
        // Valid load colliding with a matching x, new pattern 001
        add(1, 1, 0, 3, 8'h05, 1, 0, 0);
        add(1, 0, 0, 3, 8'h05, 1, 0, 0);
        add(1, 1, 1, 3, 8'h01, 1, 0, 0);
        add(1, 1, 0, 3, 8'h01, 1, 0, 0);
        add(1, 0, 0, 3, 8'h01, 1, 0, 0);
        add(1, 0, 0, 3, 8'h01, 1, 0, 0);
        add(1, 1, 0, 3, 8'h01, 1, 1, 0);
        add(0, 0, 1, 3, 8'h05, 1, 0, 0);

        rst     = 1'b0;
        en      = 1'b1;
        x       = 1'b1;
        cfg_we  = 1'b0;
        cfg_pat = '0;
        cfg_len = 4'd3;
        cfg_ovl = 1'b1;
        #1;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
`ifdef SEQ_DETECT_P_CNT_EN
        chk("rst_cnt", 32'(match_cnt), 32'd0);
`endif
        en = 1'b0;
        x  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i], i);
        end

        // Reset mid-stream after loading 1011 non-overlapping
        cyc(0, 0, 1, 4, 8'h0B, 0, 0, 0, 100);
        cyc(1, 1, 0, 3, 8'h05, 1, 0, 0, 101);
        cyc(1, 0, 0, 3, 8'h05, 1, 0, 0, 102);
        en  = 1'b1;
        x   = 1'b1;
        rst = 1'b0;
        #2;
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_err", 32'(cfg_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 1, 0, 3, 8'h05, 1, 0, 0, 103);
        cyc(1, 0, 0, 3, 8'h05, 1, 0, 0, 104);
        cyc(1, 1, 0, 3, 8'h05, 1, 1, 0, 105);

`ifdef SEQ_DETECT_P_CNT_EN
        // Valid load clears the count, then five hits saturate CNT_W=2
        cyc(0, 0, 1, 3, 8'h05, 1, 0, 0, 200);
        chk("cnt_clr", 32'(match_cnt), 32'd0);
        for (int k = 0; k < 11; k++) begin
            cyc(1, ~k[0], 0, 3, 8'h05, 1,
                (k >= 2) && !k[0], 0, 201 + k);
            if (k == 4) begin
                chk("cnt_two", 32'(match_cnt), 32'd2);
            end
        end
        chk("cnt_sat", 32'(match_cnt), 32'd3);
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_left: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_p.md
SEQ_DETECT_P -- requirements
Module: seq_detect_p

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  qualifies x; a bit is consumed only when en=1.
REQ-006 SHALL have port x  input  1  serial data bit.
REQ-007 SHALL have port cfg_we  input  1  one-cycle configuration load strobe.
REQ-008 SHALL have port cfg_pat  input  MAX_LEN  pattern; bit [len-1] is the first bit received and bit [0] the last.
REQ-009 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
REQ-010 SHALL have port cfg_ovl  input  1  1 = overlapping, 0 = non-overlapping detection.
REQ-011 SHALL have port y  output  1  Mealy match pulse.
REQ-012 SHALL have port cfg_err  output  1  registered one-cycle pulse on a rejected configuration.
REQ-013 SHALL have port match_cnt  output  CNT_W  saturating match count (present only when SEQ_DETECT_P_CNT_EN is defined).

Function
REQ-014 SHALL keep a history shift register hist[MAX_LEN-1:0] and a fill counter fill (0..MAX_LEN, saturating); each consumed bit shifts into hist[0].
REQ-015 SHALL run a 3-state FSM: EMPTY (fill=0), FILL (0<fill<len-1), ARMED (fill>=len-1).
REQ-016 SHALL drive y combinationally as 1 only when en=1, cfg_we=0, state ARMED and {hist[len-2:0],x} equals pat[len-1:0]; otherwise y=0.
REQ-017 SHALL, on a match with ovl=1, shift x in normally and remain ARMED, so an overlapping occurrence is detected.
REQ-018 SHALL, on a match with ovl=0, clear fill to 0 and go to EMPTY, so no bit of the matched sequence is reused.
REQ-019 SHALL leave hist, fill and the state unchanged when en=0.
REQ-020 SHALL, on cfg_we=1 with 2<=cfg_len<=MAX_LEN, load pat/len/ovl, clear hist and fill, and enter EMPTY on the next edge.
REQ-021 SHALL give cfg_we priority over en in the same cycle: that x is dropped and y=0.
REQ-022 SHALL, on cfg_we=1 with cfg_len<2 or cfg_len>MAX_LEN, leave the configuration and history unchanged, keep detecting, and pulse cfg_err for one cycle.
REQ-023 SHALL ignore pattern bits at index >= len.

Reset
REQ-024 SHALL, while rst=0, asynchronously set pat=3'b101 (zero-extended), len=3, ovl=1, hist=0, fill=0, state EMPTY, cfg_err=0, match_cnt=0; y SHALL then be 0.
REQ-025 SHALL discard any partially received sequence when reset asserts mid-stream, with no y pulse.

Configuration
REQ-026 SHALL, when SEQ_DETECT_P_CNT_EN is defined, include match_cnt, incremented on every cycle with y=1, saturating at 2^CNT_W-1, and cleared by a valid cfg_we.
REQ-027 SHALL, when SEQ_DETECT_P_CNT_EN is undefined, omit the match_cnt port and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state typedef (EMPTY/FILL/ARMED) and the reset-pattern constants (RST_PAT=101, RST_LEN=3, RST_OVL=1) in package seq_detect_p_pkg.
REQ-029 SHALL implement the saturating counter as sub-module sat_counter (parameter W), instantiated only under SEQ_DETECT_P_CNT_EN.

Verification
REQ-030 SHALL cover the reset defaults: x stream 1,0,1,0,1 with en=1 -> y=1 on the 3rd and 5th bits.
REQ-031 SHALL cover overlap versus non-overlap: load pat=1011, len=4, then stream 1,0,1,1,0,1,1 -> with ovl=1, y on bits 4 and 7; with ovl=0, y on bit 4 only.
REQ-032 SHALL cover en gaps: the 101 stream with en=0 cycles inserted between bits -> y only in the en=1 cycle carrying the final 1; hist is unchanged across the gaps.
REQ-033 SHALL cover config collision and error: cfg_we with cfg_len=1 -> cfg_err pulses and detection of 101 continues; a valid cfg_we in the same cycle as a matching x -> y=0 and fill=0.
REQ-034 SHALL cover reset mid-stream: bits 1,0 then rst low then 1 -> no y pulse.
REQ-035 SHALL cover counter saturation (SEQ_DETECT_P_CNT_EN, CNT_W=2): 5 matches -> match_cnt=3.
